spike_activity_monitor: RTL and testbench
=========================================

Name: spike_activity_monitor

Overview:
Parametrised windowed activity monitor for the spiking Hopfield network.
- Samples the N-wide spike vector every clock and reports an instantaneous popcount.
- On a start request, integrates activity over a window of 2^WINDOW_LOG2 samples, tracks the peak popcount, and flags convergence (identical spike vectors over the last STABLE_CYCLES samples of the window).
- Sits between the hopfield network and the top-level status pins; replaces the fixed 7-neuron activity counter.

Parameters:
N_NEURONS, 7, spike vector width (>=2)
WINDOW_LOG2, 4, window length = 2^WINDOW_LOG2 samples (1..8)
STABLE_CYCLES, 8, identical consecutive samples required for convergence (2..2^WINDOW_LOG2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
spikes_i  in  N_NEURONS  neuron spike vector, sampled every posedge
start_i  in  1  window start request, level-sampled, accepted only in IDLE
busy_o  out  1  high while in RUN
done_o  out  1  one-cycle pulse, window results valid
inst_count_o  out  CW=$clog2(N_NEURONS+1)  registered popcount of spikes_i
window_sum_o  out  CW+WINDOW_LOG2  sum of popcounts over last window
peak_o  out  CW  max popcount over last window
converged_o  out  1  last window ended with a STABLE_CYCLES-long identical run

Behaviour:
- Reset: clk is the clock; rst_n is asynchronous, active-low. While rst_n is low every register clears:
  - outputs: all 0
  - FSM: IDLE
  - internal: accumulators, sample counter, run counter, previous-vector register all 0
- inst_count_o: popcount(spikes_i) registered each cycle in every state, 1-cycle latency.
- FSM IDLE:
  - start_i=1 at a posedge -> RUN.
  - On that same edge: clear sum accumulator, peak, sample counter and run counter.
  - Result outputs hold their previous values.
- FSM RUN:
  - Each posedge takes one sample s=spikes_i.
  - acc += popcount(s).
  - peak = max(peak, popcount(s)).
  - Run counter: on the first sample, run=1. Afterwards, s==prev gives run=min(run+1,STABLE_CYCLES); otherwise run=1.
  - prev=s.
  - start_i is ignored.
- RUN exit: on the 2^WINDOW_LOG2-th sample edge -> DONE.
  - On that same edge, latch window_sum_o, peak_o, and converged_o=(run_next==STABLE_CYCLES); run_next includes that final sample.
- FSM DONE: one cycle; done_o=1, busy_o=0; start_i ignored; -> IDLE.
- busy_o: 1 exactly during the 2^WINDOW_LOG2 RUN cycles. Start accepted at edge k gives samples at edges k+1..k+2^WINDOW_LOG2 and done_o high in the following cycle.
- Widths: window_sum_o cannot overflow; its maximum is N_NEURONS*2^WINDOW_LOG2. All arithmetic is unsigned.
- Results persist until the next window's DONE edge.
- Reset mid-window: immediate return to IDLE, outputs 0, no done_o pulse.

Optional Feature:
SPIKE_MON_THRESH_IRQ_EN
- Defined:
  - adds input thresh_i [CW+WINDOW_LOG2] and output irq_o.
  - irq_o is a sticky flag, set at the DONE-latch edge when the latched window_sum > thresh_i.
  - irq_o is cleared at the next accepted start or on reset.
- Undefined: neither port exists and there is no threshold logic.

Decomposition:
- Package spike_mon_pkg holds:
  - state typedef (IDLE, RUN, DONE)
  - width helper function cnt_width(n)=$clog2(n+1)
- Sub-module spike_popcount (param N, combinational popcount). It is instantiated once; its result feeds both inst_count_o and the accumulator.

Test Plan:
All scenarios use the defaults: N=7, WINDOW_LOG2=4, STABLE_CYCLES=8.
1. Reset held with spikes_i=7'h7F -> all outputs 0; after release, inst_count_o=7 one cycle later, busy_o=0.
2. start pulse, spikes_i=7'b1010101 constant for 16 cycles -> busy_o high 16 cycles, done_o pulse once, window_sum_o=64, peak_o=4, converged_o=1.
3. start, spikes alternate 7'h7F/7'h00 for 16 samples -> window_sum_o=56, peak_o=7, converged_o=0.
4. Convergence boundary, 16-sample windows:
   - 9 distinct vectors then 7 identical -> converged_o=0.
   - 8 distinct then 8 identical -> converged_o=1.
   - All 7'h7F -> window_sum_o=112 (max, no overflow).
5. start held high continuously -> back-to-back windows, each 16 RUN + 1 DONE cycle; start asserted mid-RUN has no effect. rst_n low at sample 5 -> IDLE, no done_o, results 0.
6. SPIKE_MON_THRESH_IRQ_EN, thresh_i=50:
   - scenario 2 stimulus (sum 64) -> irq_o=1 at the done_o cycle, holds through IDLE.
   - next start clears irq_o.
   - thresh_i=64 -> irq_o stays 0.

Source files
------------

// File: rtl/spike_mon_pkg.sv
// spike_mon_pkg: shared FSM state encoding and counter width helper for the spike activity monitor
package spike_mon_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/spike_popcount.sv
// spike_popcount: combinational population count of an N-wide spike vector
module spike_popcount #(
  parameter int N  = 7,
  parameter int CW = 3
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + CW'(bits[i]);
  end
endmodule

// File: rtl/spike_activity_monitor.sv
// spike_activity_monitor: windowed spike popcount integrator with peak tracking and convergence detect
// Optional threshold interrupt (thresh_i/irq_o) enabled by defining SPIKE_MON_THRESH_IRQ_EN
module spike_activity_monitor
  import spike_mon_pkg::*;
#(
  parameter int N_NEURONS     = 7,
  parameter int WINDOW_LOG2   = 4,
  parameter int STABLE_CYCLES = 8,
  localparam int CW = cnt_width(N_NEURONS),
  localparam int SW = CW + WINDOW_LOG2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_NEURONS-1:0] spikes_i,
  input  logic                 start_i,
`ifdef SPIKE_MON_THRESH_IRQ_EN
  input  logic [SW-1:0]        thresh_i,
  output logic                 irq_o,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CW-1:0]        inst_count_o,
  output logic [SW-1:0]        window_sum_o,
  output logic [CW-1:0]        peak_o,
  output logic                 converged_o
);
  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
  state_t                 state;
  logic [SW-1:0]          acc, acc_next;
  logic [CW-1:0]          peak, peak_next, pc;
  logic [WINDOW_LOG2-1:0] cnt;
  logic [RW-1:0]          run, run_next;
  logic [N_NEURONS-1:0]   prev;
  logic                   last;
  spike_popcount #(.N(N_NEURONS), .CW(CW)) u_pop (.bits(spikes_i), .count(pc));
  assign acc_next  = acc + SW'(pc);
  assign peak_next = pc > peak ? pc : peak;
  assign run_next  = (cnt == '0 || spikes_i != prev) ? RW'(1) : run == RUN_MAX ? run : run + RW'(1);
  assign last      = cnt == '1;
  assign busy_o    = state == RUN;
  assign done_o    = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      peak         <= '0;
      cnt          <= '0;
      run          <= '0;
      prev         <= '0;
      inst_count_o <= '0;
      window_sum_o <= '0;
      peak_o       <= '0;
      converged_o  <= 1'b0;
    end else begin
      inst_count_o <= pc;
      case (state)
        IDLE: if (start_i) begin
          state <= RUN;
          acc   <= '0;
          peak  <= '0;
          cnt   <= '0;
          run   <= '0;
        end
        RUN: begin
          acc  <= acc_next;
          peak <= peak_next;
          run  <= run_next;
          prev <= spikes_i;
          cnt  <= cnt + WINDOW_LOG2'(1);
          if (last) begin
            state        <= DONE;
            window_sum_o <= acc_next;
            peak_o       <= peak_next;
            converged_o  <= run_next == RUN_MAX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SPIKE_MON_THRESH_IRQ_EN
  // Sticky until the next accepted start so software can poll after the window ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_o <= 1'b0;
    else if (state == IDLE && start_i) irq_o <= 1'b0;
    else if (state == RUN && last && acc_next > thresh_i) irq_o <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_spike_activity_monitor.sv
// tb_spike_activity_monitor: directed table-driven checks of the spike activity monitor (default parameters)
module tb_spike_activity_monitor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] spikes_i = '0;
  logic       start_i = 1'b0;
  logic       busy_o, done_o, converged_o;
  logic [2:0] inst_count_o, peak_o;
  logic [6:0] window_sum_o;
`ifdef SPIKE_MON_THRESH_IRQ_EN
  logic [6:0] thresh_i = '0;
  logic       irq_o;
`endif
  int checks = 0;
  int errors = 0;

  spike_activity_monitor dut (
    .clk(clk), .rst_n(rst_n), .spikes_i(spikes_i), .start_i(start_i),
`ifdef SPIKE_MON_THRESH_IRQ_EN
    .thresh_i(thresh_i), .irq_o(irq_o),
`endif
    .busy_o(busy_o), .done_o(done_o), .inst_count_o(inst_count_o),
    .window_sum_o(window_sum_o), .peak_o(peak_o), .converged_o(converged_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [15:0][6:0] s;
    int               sum;
    int               peak;
    int               conv;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_window(input vec_t v);
    int busy_n = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (busy_o) busy_n++;
      if (i > 0) chk({v.name, "_inst"}, inst_count_o, $countones(v.s[i-1]));
      spikes_i = v.s[i];
      @(negedge clk);
    end
    chk({v.name, "_busy_cycles"}, busy_n, 16);
    chk({v.name, "_done"}, done_o, 1);
    chk({v.name, "_busy_at_done"}, busy_o, 0);
    chk({v.name, "_sum"}, window_sum_o, v.sum);
    chk({v.name, "_peak"}, peak_o, v.peak);
    chk({v.name, "_conv"}, converged_o, v.conv);
    @(negedge clk);
    chk({v.name, "_done_pulse_end"}, done_o, 0);
  endtask

  initial begin
    int dones, busy_n, gap, last_done;
    vecs[0].name = "const55"; vecs[0].sum = 64;  vecs[0].peak = 4; vecs[0].conv = 1;
    vecs[1].name = "alt7f";   vecs[1].sum = 56;  vecs[1].peak = 7; vecs[1].conv = 0;
    vecs[2].name = "d9s7";    vecs[2].sum = 29;  vecs[2].peak = 3; vecs[2].conv = 0;
    vecs[3].name = "d8s8";    vecs[3].sum = 29;  vecs[3].peak = 3; vecs[3].conv = 1;
    vecs[4].name = "all7f";   vecs[4].sum = 112; vecs[4].peak = 7; vecs[4].conv = 1;
    for (int i = 0; i < 16; i++) begin
      vecs[0].s[i] = 7'b1010101;
      vecs[1].s[i] = (i % 2 == 1) ? 7'h00 : 7'h7F;
      vecs[2].s[i] = (i < 9) ? 7'(i + 1) : 7'd10;
      vecs[3].s[i] = (i < 8) ? 7'(i + 1) : 7'd10;
      vecs[4].s[i] = 7'h7F;
    end
    // reset with all spikes high
    spikes_i = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst_inst", inst_count_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_sum", window_sum_o, 0);
    chk("rst_peak", peak_o, 0);
    chk("rst_conv", converged_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_inst", inst_count_o, 7);
    chk("post_rst_busy", busy_o, 0);
    foreach (vecs[k]) run_window(vecs[k]);
    // results persist through idle
    spikes_i = 7'h00;
    repeat (4) @(negedge clk);
    chk("hold_sum", window_sum_o, 112);
    chk("hold_peak", peak_o, 7);
    chk("hold_busy", busy_o, 0);
    // start held high: back-to-back windows
    dones = 0; busy_n = 0; gap = 0; last_done = 0;
    spikes_i = 7'b1010101;
    start_i = 1'b1;
    for (int c = 0; c < 100 && dones < 2; c++) begin
      @(negedge clk);
      if (busy_o) busy_n++;
      if (done_o) begin
        if (dones == 1) gap = c - last_done;
        last_done = c;
        dones++;
      end
    end
    start_i = 1'b0;
    chk("b2b_dones", dones, 2);
    chk("b2b_busy", busy_n, 32);
    chk("b2b_gap", gap, 18);
    chk("b2b_sum", window_sum_o, 64);
    chk("b2b_conv", converged_o, 1);
    // reset in the middle of a window
    repeat (2) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_before", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_sum", window_sum_o, 0);
    chk("mid_rst_peak", peak_o, 0);
    chk("mid_rst_conv", converged_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0; busy_n = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_o) dones++;
      if (busy_o) busy_n++;
    end
    chk("mid_rst_no_done", dones, 0);
    chk("mid_rst_idle", busy_n, 0);
`ifdef SPIKE_MON_THRESH_IRQ_EN
    thresh_i = 7'd50;
    chk("irq_rst", irq_o, 0);
    run_window(vecs[0]);
    chk("irq_set", irq_o, 1);
    repeat (3) @(negedge clk);
    chk("irq_hold", irq_o, 1);
    thresh_i = 7'd64;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("irq_clear_on_start", irq_o, 0);
    repeat (16) @(negedge clk);
    chk("irq_eq_done", done_o, 1);
    chk("irq_eq_thresh", irq_o, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
